// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_SIGNED_EN to treat bin as two's complement and report its sign on neg.
module bcd_bin_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [WIDTH-1:0]    sr;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] scr;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scr_nxt;
  logic [CW-1:0]       cnt;
  logic                ovf;
  logic                ovf_nxt;
  logic                sgn;
  logic                sgn_in;
  logic                last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = scr[4*d+:4] >= 4'd5 ? scr[4*d+:4] + 4'd3 : scr[4*d+:4];
  end
  // The bit leaving the top digit is lost from bcd but remembered as overflow.
  assign scr_nxt = {adj[4*DIGITS-2:0], sr[WIDTH-1]};
  assign ovf_nxt = ovf | adj[4*DIGITS-1];
  assign last    = cnt == CW'(WIDTH - 1);
`ifdef BCD_SIGNED_EN
  assign sgn_in = bin[WIDTH-1];
  assign mag    = sgn_in ? -bin : bin;
`else
  assign sgn_in = 1'b0;
  assign mag    = bin;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      neg      <= 1'b0;
      sr       <= '0;
      scr      <= '0;
      ovf      <= 1'b0;
      sgn      <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SHIFT: begin
          sr  <= sr << 1;
          scr <= scr_nxt;
          ovf <= ovf_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= scr_nxt;
            overflow <= ovf_nxt;
            neg      <= sgn;
          end
        end
        default: begin
          state <= IDLE;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            sr    <= mag;
            scr   <= '0;
            ovf   <= 1'b0;
            sgn   <= sgn_in;
            cnt   <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_bin_seq.sv
// tb_bcd_bin_seq: vector table plus scoreboard checks for three bcd_bin_seq configurations.
module tb_bcd_bin_seq;
  typedef struct packed {logic [19:0] bcd; logic ovf; logic neg;} exp_t;
  typedef struct {logic [7:0] bin; logic [11:0] bcd; logic ovf; logic neg;} vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [7:0]  bin1 = '0;
  logic [7:0]  bin2 = '0;
  logic [15:0] bin3 = '0;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;
  logic [19:0] bcd3;
  logic        ovf1, ovf2, ovf3, neg1, neg2, neg3;
  exp_t        q1[$], q2[$], q3[$];
  exp_t        e1, e2, e3;
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  bcd_bin_seq #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin1),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd1), .overflow(ovf1), .neg(neg1));
  bcd_bin_seq #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin2),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd2), .overflow(ovf2), .neg(neg2));
  bcd_bin_seq #(.WIDTH(16), .DIGITS(5)) dut3 (.clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin3),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd3), .overflow(ovf3), .neg(neg3));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: done pulse with no pending conversion at %0t", name, $time);
  endtask
  always @(negedge clk) if (done_v[0]) begin
    if (q1.size() == 0) unexpected("done1");
    else begin
      e1 = q1.pop_front();
      chk("bcd1", 32'(bcd1), 32'(e1.bcd));
      chk("ovf1", 32'(ovf1), 32'(e1.ovf));
      chk("neg1", 32'(neg1), 32'(e1.neg));
    end
  end
  always @(negedge clk) if (done_v[1]) begin
    if (q2.size() == 0) unexpected("done2");
    else begin
      e2 = q2.pop_front();
      chk("bcd2", 32'(bcd2), 32'(e2.bcd));
      chk("ovf2", 32'(ovf2), 32'(e2.ovf));
      chk("neg2", 32'(neg2), 32'(e2.neg));
    end
  end
  always @(negedge clk) if (done_v[2]) begin
    if (q3.size() == 0) unexpected("done3");
    else begin
      e3 = q3.pop_front();
      chk("bcd3", 32'(bcd3), 32'(e3.bcd));
      chk("ovf3", 32'(ovf3), 32'(e3.ovf));
      chk("neg3", 32'(neg3), 32'(e3.neg));
    end
  end
  task automatic push(input int k, input logic [19:0] eb, input logic eo, input logic en);
    case (k)
      0: q1.push_back(exp_t'{eb, eo, en});
      1: q2.push_back(exp_t'{eb, eo, en});
      default: q3.push_back(exp_t'{eb, eo, en});
    endcase
  endtask
  task automatic conv(input int k, input logic [15:0] b, input logic [19:0] eb, input logic eo,
                      input logic en, input int lat);
    int n, bc;
    @(negedge clk);
    case (k)
      0: bin1 = b[7:0];
      1: bin2 = b[7:0];
      default: bin3 = b;
    endcase
    push(k, eb, eo, en);
    start_v[k] = 1'b1;
    n = 0;
    bc = 0;
    do begin
      @(negedge clk);
      start_v[k] = 1'b0;
      n++;
      bc += int'(busy_v[k]);
    end while (!done_v[k] && n < 40);
    chk("latency", n, lat);
    chk("busy_cycles", bc, lat - 1);
    chk("busy_at_done", 32'(busy_v[k]), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done_v[k]), 0);
  endtask
  initial begin
    int n;
    logic [7:0]  b2b_in[3];
    logic [11:0] b2b_out[3];
    b2b_in  = '{8'd0, 8'd9, 8'd100};
    b2b_out = '{12'h000, 12'h009, 12'h100};
`ifdef BCD_SIGNED_EN
    tbl = '{'{8'h80, 12'h128, 1'b0, 1'b1}, '{8'hFF, 12'h001, 1'b0, 1'b1}, '{8'h7F, 12'h127, 1'b0, 1'b0},
            '{8'h00, 12'h000, 1'b0, 1'b0}, '{8'h09, 12'h009, 1'b0, 1'b0}, '{8'hF6, 12'h010, 1'b0, 1'b1},
            '{8'h9C, 12'h100, 1'b0, 1'b1}, '{8'h64, 12'h100, 1'b0, 1'b0}};
`else
    tbl = '{'{8'd255, 12'h255, 1'b0, 1'b0}, '{8'd0, 12'h000, 1'b0, 1'b0}, '{8'd9, 12'h009, 1'b0, 1'b0},
            '{8'd100, 12'h100, 1'b0, 1'b0}, '{8'd37, 12'h037, 1'b0, 1'b0}, '{8'd128, 12'h128, 1'b0, 1'b0},
            '{8'd1, 12'h001, 1'b0, 1'b0}, '{8'd200, 12'h200, 1'b0, 1'b0}, '{8'd99, 12'h099, 1'b0, 1'b0},
            '{8'd123, 12'h123, 1'b0, 1'b0}};
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v), 0);
    chk("rst_done", 32'(done_v), 0);
    chk("rst_bcd", 32'(bcd1), 0);
    chk("rst_ovf", 32'({ovf1, ovf2, ovf3}), 0);
    chk("rst_neg", 32'({neg1, neg2, neg3}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    foreach (tbl[i]) conv(0, 16'(tbl[i].bin), 20'(tbl[i].bcd), tbl[i].ovf, tbl[i].neg, 9);
    // back-to-back: start held high through each DONE cycle
    @(negedge clk);
    bin1 = b2b_in[0];
    push(0, 20'(b2b_out[0]), 1'b0, 1'b0);
    start_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!done_v[0] && n < 30);
      chk("b2b_gap", n, 9);
      if (i < 2) begin
        bin1 = b2b_in[i+1];
        push(0, 20'(b2b_out[i+1]), 1'b0, 1'b0);
      end else start_v[0] = 1'b0;
    end
    repeat (2) @(negedge clk);
    // start requests during SHIFT are ignored
    bin1 = 8'd37;
    push(0, 20'h037, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    bin1 = 8'd200;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 5;
    while (!done_v[0] && n < 30) begin @(negedge clk); n++; end
    chk("ignore_latency", n, 9);
    repeat (15) @(negedge clk);
    // reset during a conversion aborts with no done pulse
    bin1 = 8'd123;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy_v[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_bcd", 32'(bcd1), 0);
    chk("abort_done", 32'(done_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    conv(0, 16'd123, 20'h123, 1'b0, 1'b0, 9);
`ifdef BCD_SIGNED_EN
    conv(1, 16'h63, 20'h99, 1'b0, 1'b0, 9);
    conv(1, 16'hFF, 20'h01, 1'b0, 1'b1, 9);
    conv(1, 16'h9C, 20'h00, 1'b1, 1'b1, 9);
    conv(2, 16'hFFFF, 20'h00001, 1'b0, 1'b1, 17);
`else
    conv(1, 16'd99, 20'h99, 1'b0, 1'b0, 9);
    conv(1, 16'd255, 20'h55, 1'b1, 1'b0, 9);
    conv(1, 16'd100, 20'h00, 1'b1, 1'b0, 9);
    conv(2, 16'd65535, 20'h65535, 1'b0, 1'b0, 17);
`endif
    conv(1, 16'd0, 20'h00, 1'b0, 1'b0, 9);
    conv(2, 16'd10000, 20'h10000, 1'b0, 1'b0, 17);
    repeat (5) @(negedge clk);
    chk("queues_drained", q1.size() + q2.size() + q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
